// File: rtl/lvdc_bus_tracer_if.sv
// Snoop, control and drain signals of the LVDC memory-bus tracer.
// The bench drives through master; the tracer connects as slave.
interface lvdc_bus_tracer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 26,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = TS_W + ADDR_W + DATA_W;

  logic              mon_valid;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_data;
  logic              arm;
  logic              stop;
  logic              ring;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] trig_mask;
  logic              out_valid;
  logic              out_ready;
  logic [ENT_W-1:0]  out_data;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;
  logic              overflow;
  logic              done;

  modport master (
    output mon_valid, mon_addr, mon_data, arm, stop, ring, trig_addr, trig_mask, out_ready,
    input  out_valid, out_data, count, state, overflow, done
  );

  modport slave (
    input  mon_valid, mon_addr, mon_data, arm, stop, ring, trig_addr, trig_mask, out_ready,
    output out_valid, out_data, count, state, overflow, done
  );
endinterface

// File: rtl/lvdc_bus_tracer.sv
// Memory-bus trace capture: arms, triggers on a masked address match, buffers
// timestamped {addr, data} samples and drains them oldest-first.
module lvdc_bus_tracer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 26,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  lvdc_bus_tracer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TS_W + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(DEPTH - 1);
  localparam logic [TS_W-1:0]  TS_MAX   = '1;
  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ring_q, ring_d;
  logic              ovf_q, ovf_d;

  logic              match;
  logic              trig_hit;
  logic              wr_en;
  logic              pop;
  logic              out_valid;
  logic [TS_W-1:0]   wr_ts;

  assign match = ((bus.mon_addr ^ bus.trig_addr) & bus.trig_mask) == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // arm beats stop, stop beats the one-shot full condition
  always_comb begin
    state_d = state_q;
    if (bus.arm) begin
      state_d = S_ARMED;
    end else begin
      unique case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_ARMED:   if (bus.mon_valid && match) state_d = S_CAPTURE;
        S_CAPTURE: begin
          if (bus.stop) begin
            state_d = S_DONE;
          end else if (bus.mon_valid && !ring_q && count_q == FULL_M1) begin
            state_d = S_DONE;
          end
        end
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    trig_hit  = !bus.arm && state_q == S_ARMED && bus.mon_valid && match;
    wr_en     = trig_hit || (!bus.arm && state_q == S_CAPTURE && bus.mon_valid);
    wr_ts     = (state_q == S_ARMED) ? '0 : ts_q;
    out_valid = state_q == S_DONE && count_q != '0;
    pop       = !bus.arm && out_valid && bus.out_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ts_d     = ts_q;
    ring_d   = ring_q;
    ovf_d    = ovf_q;
    if (bus.arm) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ts_d     = '0;
      ring_d   = bus.ring;
      ovf_d    = 1'b0;
    end else begin
      if (state_q == S_CAPTURE && ts_q != TS_MAX) ts_d = ts_q + 1'b1;
      if (trig_hit) ts_d = TS_ONE;
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        // only ring mode can reach a write while full: drop the oldest entry
        if (count_q == FULL) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          ovf_d    = 1'b1;
        end else begin
          count_d  = count_q + 1'b1;
        end
      end else if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ts_q     <= '0;
      ring_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ts_q     <= ts_d;
      ring_q   <= ring_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_ts, bus.mon_addr, bus.mon_data};
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;
  assign bus.state     = state_q;
  assign bus.overflow  = ovf_q;
  assign bus.done      = state_q == S_DONE;
endmodule
